// File: rtl/rv32_cpu_cp_shifter_pkg.sv
// rv32_cpu_cp_shifter_pkg: FSM encoding, latched mode bundle and shamt-width helper shared by the multi-cycle shifter
package rv32_cpu_cp_shifter_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = S_IDLE, RUN = S_RUN, DONE = S_DONE} state_t;
  typedef struct packed {
    logic right;
    logic arith;
    logic rotate;
  } mode_t;
  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction
endpackage

// File: rtl/rv32_cpu_cp_shifter_step.sv
// rv32_cpu_cp_shifter_step: combinational 0..STEP-bit shift/rotate of d by k under mode -> q (rotate only with RV32_CPU_CP_SHIFTER_ROTATE_EN)
module rv32_cpu_cp_shifter_step
  import rv32_cpu_cp_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  parameter int KW   = $clog2(STEP) + 1
) (
  input  logic [XLEN-1:0] d,
  input  logic [KW-1:0]   k,
  input  mode_t           mode,
  output logic [XLEN-1:0] q
);
  logic [XLEN-1:0] sh_r;
  logic [XLEN-1:0] sh_l;
  assign sh_r = XLEN'({{XLEN{mode.arith & d[XLEN-1]}}, d} >> k);
  assign sh_l = d << k;
`ifdef RV32_CPU_CP_SHIFTER_ROTATE_EN
  logic [31:0]     rot_amt;
  logic [XLEN-1:0] rot;
  // rotate-left by k is rotate-right by XLEN-k over the doubled word
  assign rot_amt = mode.right ? 32'(k) : 32'(XLEN) - 32'(k);
  assign rot     = XLEN'({d, d} >> rot_amt);
  assign q       = mode.rotate ? rot : mode.right ? sh_r : sh_l;
`else
  logic unused_rotate;
  assign unused_rotate = mode.rotate;
  assign q             = mode.right ? sh_r : sh_l;
`endif
endmodule

// File: rtl/rv32_cpu_cp_shifter_mc.sv
// rv32_cpu_cp_shifter_mc: multi-cycle STEP-bits/cycle shifter; i_clk,i_rstn,i_cpu_trap,i_start,mode bits,i_rs1,i_shamt -> o_res,o_busy,o_valid; rotate via RV32_CPU_CP_SHIFTER_ROTATE_EN
module rv32_cpu_cp_shifter_mc
  import rv32_cpu_cp_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_cpu_trap,
  input  logic                     i_start,
  input  logic                     i_shift_right,
  input  logic                     i_shift_arth,
  input  logic                     i_rotate,
  input  logic [XLEN-1:0]          i_rs1,
  input  logic [shamt_w(XLEN)-1:0] i_shamt,
  output logic [XLEN-1:0]          o_res,
  output logic                     o_busy,
  output logic                     o_valid
);
  localparam int SW = shamt_w(XLEN);
  localparam int CW = SW + 1;
  localparam int KW = $clog2(STEP) + 1;
  state_t          state_q, state_d;
  mode_t           mode_q, mode_d, mode_in;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d, step_res;
  logic [KW-1:0]   k;
  logic            busy_q, busy_d, valid_q, valid_d, last, rot_in;
`ifdef RV32_CPU_CP_SHIFTER_ROTATE_EN
  assign rot_in = i_rotate;
`else
  logic unused_rotate;
  assign unused_rotate = i_rotate;
  assign rot_in        = 1'b0;
`endif
  assign mode_in = {i_shift_right, i_shift_arth, rot_in};
  assign last    = cnt_q <= CW'(STEP);
  assign k       = last ? cnt_q[KW-1:0] : KW'(STEP);
  rv32_cpu_cp_shifter_step #(.XLEN(XLEN), .STEP(STEP), .KW(KW)) u_step (
    .d    (res_q),
    .k    (k),
    .mode (mode_q),
    .q    (step_res)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (i_cpu_trap) begin
      state_d = IDLE;
    end else if (i_start) begin
      state_d = (i_shamt == '0) ? DONE : RUN;
      mode_d  = mode_in;
      cnt_d   = CW'(i_shamt);
      res_d   = i_rs1;
    end else if (state_q == RUN) begin
      state_d = last ? DONE : RUN;
      cnt_d   = cnt_q - CW'(k);
      res_d   = step_res;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign busy_d  = state_d == RUN;
  assign valid_d = state_d == DONE;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign o_res   = res_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
endmodule

// File: doc/rv32_cpu_cp_shifter_mc.md
Name: rv32_cpu_cp_shifter_mc

Overview:
- Multi-cycle, parametrised shift co-processor for the CPU ALU co-processor slot.
- Generalises the 1-bit-per-cycle serial shifter: configurable XLEN and bits-per-cycle (STEP).
- Adds explicit zero-shift completion, restart-while-busy and an optional rotate mode.
- Started by the CPU's execute stage. Returns the result with a one-cycle valid pulse.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- STEP, 4, maximum bits shifted per cycle; a power of 2 in 1..XLEN.

Ports:
- i_clk  in  1  global clock, rising edge
- i_rstn  in  1  global reset, asynchronous, active low
- i_cpu_trap  in  1  CPU entering trap; aborts any operation
- i_start  in  1  single-cycle start strobe; operands sampled on this cycle
- i_shift_right  in  1  1 = right, 0 = left
- i_shift_arth  in  1  arithmetic fill for right shifts; ignored for left shifts and rotates
- i_rotate  in  1  rotate instead of shift (only with the optional feature)
- i_rs1  in  XLEN  operand
- i_shamt  in  $clog2(XLEN)  shift amount, unsigned
- o_res  out  XLEN  result; holds its value until the next start
- o_busy  out  1  operation in progress (RUN state)
- o_valid  out  1  one-cycle pulse; o_res is final on that cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_rstn).
- Reset values: state = IDLE, counter = 0, o_res = 0, o_busy = 0, o_valid = 0.
- Latched mode: right, arith and rotate are captured at start and held for the whole operation.
- FSM states: IDLE, RUN, DONE.
- IDLE, i_start, shamt = 0: load o_res = i_rs1, go to DONE.
- IDLE, i_start, shamt > 0: load o_res = i_rs1, counter = shamt, go to RUN.
- RUN, each cycle: k = min(STEP, counter); shift o_res by k using the latched mode; counter -= k.
- RUN exit: go to DONE when counter <= STEP (that is, on the final shift).
- DONE: o_valid = 1 for exactly this cycle; next state is IDLE, or reload as from IDLE if i_start is high.
- Latency: start sampled at cycle T; o_valid at T+1 for shamt = 0, otherwise at T+1+ceil(shamt/STEP).
- Right-shift fill: sign bit of the current o_res when arith = 1, else 0.
- Left-shift fill: 0.
- Rotate: bits shifted out re-enter at the opposite end.
- i_start in RUN or DONE: abort the current operation with no valid for it, then reload from the new operands (restart).
- i_cpu_trap in any state: go to IDLE next cycle with o_valid = 0. o_res is unspecified after a trap.
- Trap and start in the same cycle: trap wins; the start is dropped.
- Asynchronous reset mid-operation: immediate return to the reset values.
- Counter width: $clog2(XLEN)+1 bits. No wrap is possible, because k <= counter.

Optional Feature:
- Macro: RV32_CPU_CP_SHIFTER_ROTATE_EN.
- Defined: i_rotate is honoured; ROL when i_shift_right = 0, ROR when i_shift_right = 1.
- Undefined: i_rotate is ignored and the operation is a plain shift. No rotate logic is synthesised.

Decomposition:
- Package rv32_cpu_cp_shifter_pkg holds:
  - FSM state encoding (IDLE/RUN/DONE localparams);
  - a function computing the shamt width, $clog2(XLEN);
  - a mode-bundle typedef {right, arith, rotate}.
- Sub-module rv32_cpu_cp_shifter_step: combinational 0..STEP-bit shift/rotate of one XLEN word, taking k and the mode bundle.
  - Instantiated once in the RUN datapath.

Test Plan:
- Use XLEN=32, STEP=4 unless stated.
- SLL, rs1 = 0x0000_0001, shamt = 5 -> o_valid at T+3 only; o_res = 0x0000_0020; o_busy high at T+1 and T+2.
- SRA, rs1 = 0x8000_0000, shamt = 31 -> o_valid at T+9; o_res = 0xFFFF_FFFF. SRL with the same operands -> 0x0000_0001.
- shamt = 0, rs1 = 0xDEAD_BEEF -> o_valid at T+1, o_res = 0xDEAD_BEEF, o_busy never high.
- SLL shamt = 20, i_cpu_trap at T+2 -> no o_valid through T+10; o_busy low from T+3. Trap + start in the same cycle -> start ignored.
- SLL shamt = 16 started at T, then SRL rs1 = 0x100, shamt = 4 started at T+2 -> a single o_valid at T+4 with o_res = 0x10.
- ROR rs1 = 0x0000_00F1, shamt = 4, i_rotate = 1 -> 0x1000_000F at T+2 with the macro defined; 0x0000_000F without it.
- Repeat the first scenario with STEP = 1 (valid at T+6) and with XLEN = 64, STEP = 8, shamt = 63 (valid at T+9).
